// File: rtl/reg_dest_pipeline.sv
// Destination-register pipeline: carries each instruction's write destination through DEPTH
// stages to writeback and reports read-after-write hazards against in-flight destinations.
module reg_dest_pipeline #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DEPTH  = 3,
  parameter int unsigned SP_IDX = 29,
  parameter int unsigned RA_IDX = 31
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic [1:0]                   sel_i,
  input  logic [ADDR_W-1:0]            instr_rt_i,
  input  logic [ADDR_W-1:0]            instr_rd_i,
  input  logic                         in_valid_i,
  input  logic                         stall_i,
  input  logic                         flush_i,
  input  logic [ADDR_W-1:0]            src_a_i,
  input  logic [ADDR_W-1:0]            src_b_i,
  output logic [ADDR_W-1:0]            wb_addr_o,
  output logic                         wb_we_o,
  output logic                         hazard_a_o,
  output logic                         hazard_b_o,
  output logic [$clog2(DEPTH+1)-1:0]   dist_a_o,
  output logic [$clog2(DEPTH+1)-1:0]   dist_b_o
);

  localparam int unsigned DistW = $clog2(DEPTH + 1);
  localparam int unsigned Last  = DEPTH - 1;
  localparam logic [ADDR_W-1:0] SpAddr = ADDR_W'(SP_IDX);
  localparam logic [ADDR_W-1:0] RaAddr = ADDR_W'(RA_IDX);

  logic [DEPTH-1:0]  valid_q;
  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [ADDR_W-1:0] dest_sel;
  logic [DistW-1:0]  dist_a, dist_b;

  always_comb begin
    dest_sel = instr_rt_i;
    unique case (sel_i)
      2'b00: dest_sel = instr_rt_i;
      2'b01: dest_sel = SpAddr;
      2'b10: dest_sel = RaAddr;
      2'b11: dest_sel = instr_rd_i;
      default: dest_sel = instr_rt_i;
    endcase
  end

  // Flush only clears valid bits; stale addresses are harmless once invalid.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= '0;
      for (int k = 0; k < int'(DEPTH); k++) begin
        addr_q[k] <= '0;
      end
    end else if (flush_i) begin
      valid_q <= '0;
    end else if (!stall_i) begin
      valid_q[0] <= in_valid_i;
      addr_q[0]  <= dest_sel;
      for (int k = 1; k < int'(DEPTH); k++) begin
        valid_q[k] <= valid_q[k-1];
        addr_q[k]  <= addr_q[k-1];
      end
    end
  end

  // Walk oldest to youngest so the youngest match overwrites older ones.
  always_comb begin
    dist_a = '0;
    dist_b = '0;
    for (int k = int'(DEPTH) - 1; k >= 0; k--) begin
      if (valid_q[k] && (addr_q[k] != '0)) begin
        if (addr_q[k] == src_a_i) dist_a = DistW'(k + 1);
        if (addr_q[k] == src_b_i) dist_b = DistW'(k + 1);
      end
    end
  end

  assign dist_a_o   = dist_a;
  assign dist_b_o   = dist_b;
  assign hazard_a_o = (dist_a != '0);
  assign hazard_b_o = (dist_b != '0);
  assign wb_addr_o  = addr_q[Last];
  assign wb_we_o    = valid_q[Last] && (addr_q[Last] != '0);

endmodule

// File: tb/tb_reg_dest_pipeline.sv
// Bench for reg_dest_pipeline: directed vector table, hand-written stall/flush/reset
// sequences, then randomized traffic against a queue-based reference model.
module tb_reg_dest_pipeline;

  localparam int unsigned AW = 5;
  localparam int unsigned D  = 3;
  localparam int unsigned DW = $clog2(D + 1);

  logic          clk = 1'b0;
  logic          rst_n;
  logic [1:0]    sel;
  logic [AW-1:0] rt, rd, src_a, src_b;
  logic          in_valid, stall, flush;
  logic [AW-1:0] wb_addr;
  logic          wb_we, hazard_a, hazard_b;
  logic [DW-1:0] dist_a, dist_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  reg_dest_pipeline #(
    .ADDR_W(AW), .DEPTH(D), .SP_IDX(29), .RA_IDX(31)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .sel_i      (sel),
    .instr_rt_i (rt),
    .instr_rd_i (rd),
    .in_valid_i (in_valid),
    .stall_i    (stall),
    .flush_i    (flush),
    .src_a_i    (src_a),
    .src_b_i    (src_b),
    .wb_addr_o  (wb_addr),
    .wb_we_o    (wb_we),
    .hazard_a_o (hazard_a),
    .hazard_b_o (hazard_b),
    .dist_a_o   (dist_a),
    .dist_b_o   (dist_b)
  );

  typedef struct {
    logic [1:0] sel; logic [4:0] rt, rd; logic v, st, fl; logic [4:0] sa, sb;
    bit ca; logic [4:0] wa; logic we, ha; logic [1:0] da; logic hb; logic [1:0] db;
  } vec_t;
  vec_t vecs [19];

  typedef struct { bit v; bit k; logic [4:0] a; } ent_t;
  ent_t pipe [$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic check_outs(input string tag, input bit ca, input logic [4:0] wa,
                            input logic we, input logic ha, input logic [1:0] da,
                            input logic hb, input logic [1:0] db);
    if (ca) chk({tag, " wb_addr"}, 32'(wb_addr), 32'(wa));
    chk({tag, " wb_we"}, 32'(wb_we), 32'(we));
    chk({tag, " hazard_a"}, 32'(hazard_a), 32'(ha));
    chk({tag, " dist_a"}, 32'(dist_a), 32'(da));
    chk({tag, " hazard_b"}, 32'(hazard_b), 32'(hb));
    chk({tag, " dist_b"}, 32'(dist_b), 32'(db));
  endtask

  task automatic drive(input logic [1:0] s, input logic [4:0] t, input logic [4:0] d,
                       input logic v, input logic st, input logic fl,
                       input logic [4:0] a, input logic [4:0] b);
    sel = s; rt = t; rd = d; in_valid = v; stall = st; flush = fl; src_a = a; src_b = b;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: a queue of DEPTH entries, index 0 youngest.
  function automatic void m_reset();
    pipe.delete();
    for (int i = 0; i < int'(D); i++) pipe.push_back('{v: 1'b0, k: 1'b1, a: 5'd0});
  endfunction

  function automatic logic [4:0] m_dest(input logic [1:0] s, input logic [4:0] t,
                                        input logic [4:0] d);
    case (s)
      2'b00:   return t;
      2'b01:   return 5'd29;
      2'b10:   return 5'd31;
      default: return d;
    endcase
  endfunction

  function automatic void m_edge();
    ent_t e;
    if (flush) begin
      foreach (pipe[i]) begin
        pipe[i].v = 1'b0;
        pipe[i].k = 1'b0;
      end
    end else if (!stall) begin
      e.v = in_valid; e.k = 1'b1; e.a = m_dest(sel, rt, rd);
      pipe.push_front(e);
      void'(pipe.pop_back());
    end
  endfunction

  function automatic logic [1:0] m_dist(input logic [4:0] src);
    for (int i = 0; i < int'(D); i++)
      if (pipe[i].v && pipe[i].a != 5'd0 && pipe[i].a == src) return 2'(i + 1);
    return 2'd0;
  endfunction

  initial begin
    logic [1:0] eda, edb;
    logic [4:0] pick;
    // sel rt rd v st fl sa sb | ca wa we ha da hb db
    vecs[0]  = '{2'd3, 5'd0, 5'd8,  1'b1, 1'b0, 1'b0, 5'd8,  5'd3,  1, 5'd0,  1'b0, 1'b1, 2'd1, 1'b0, 2'd0};
    vecs[1]  = '{2'd0, 5'd0, 5'd0,  1'b0, 1'b0, 1'b0, 5'd8,  5'd8,  1, 5'd0,  1'b0, 1'b1, 2'd2, 1'b1, 2'd2};
    vecs[2]  = '{2'd0, 5'd0, 5'd0,  1'b0, 1'b0, 1'b0, 5'd8,  5'd8,  1, 5'd8,  1'b1, 1'b1, 2'd3, 1'b1, 2'd3};
    vecs[3]  = '{2'd1, 5'd0, 5'd0,  1'b1, 1'b0, 1'b0, 5'd8,  5'd29, 1, 5'd0,  1'b0, 1'b0, 2'd0, 1'b1, 2'd1};
    vecs[4]  = '{2'd2, 5'd0, 5'd0,  1'b1, 1'b0, 1'b0, 5'd29, 5'd31, 1, 5'd0,  1'b0, 1'b1, 2'd2, 1'b1, 2'd1};
    vecs[5]  = '{2'd0, 5'd5, 5'd0,  1'b0, 1'b0, 1'b0, 5'd29, 5'd31, 1, 5'd29, 1'b1, 1'b1, 2'd3, 1'b1, 2'd2};
    vecs[6]  = '{2'd0, 5'd5, 5'd0,  1'b1, 1'b0, 1'b0, 5'd5,  5'd5,  1, 5'd31, 1'b1, 1'b1, 2'd1, 1'b1, 2'd1};
    vecs[7]  = '{2'd0, 5'd0, 5'd0,  1'b0, 1'b0, 1'b0, 5'd5,  5'd5,  1, 5'd5,  1'b0, 1'b1, 2'd2, 1'b1, 2'd2};
    vecs[8]  = '{2'd0, 5'd0, 5'd0,  1'b0, 1'b0, 1'b0, 5'd5,  5'd5,  1, 5'd5,  1'b1, 1'b1, 2'd3, 1'b1, 2'd3};
    vecs[9]  = '{2'd0, 5'd0, 5'd0,  1'b0, 1'b0, 1'b0, 5'd5,  5'd5,  1, 5'd0,  1'b0, 1'b0, 2'd0, 1'b0, 2'd0};
    vecs[10] = '{2'd0, 5'd0, 5'd0,  1'b1, 1'b0, 1'b0, 5'd0,  5'd0,  1, 5'd0,  1'b0, 1'b0, 2'd0, 1'b0, 2'd0};
    vecs[11] = '{2'd0, 5'd0, 5'd0,  1'b0, 1'b0, 1'b0, 5'd0,  5'd0,  1, 5'd0,  1'b0, 1'b0, 2'd0, 1'b0, 2'd0};
    vecs[12] = '{2'd0, 5'd0, 5'd0,  1'b0, 1'b0, 1'b0, 5'd0,  5'd0,  1, 5'd0,  1'b0, 1'b0, 2'd0, 1'b0, 2'd0};
    vecs[13] = '{2'd3, 5'd0, 5'd12, 1'b1, 1'b0, 1'b0, 5'd12, 5'd12, 1, 5'd0,  1'b0, 1'b1, 2'd1, 1'b1, 2'd1};
    vecs[14] = '{2'd3, 5'd0, 5'd9,  1'b1, 1'b1, 1'b0, 5'd12, 5'd9,  1, 5'd0,  1'b0, 1'b1, 2'd1, 1'b0, 2'd0};
    vecs[15] = '{2'd3, 5'd0, 5'd9,  1'b1, 1'b0, 1'b1, 5'd12, 5'd9,  0, 5'd0,  1'b0, 1'b0, 2'd0, 1'b0, 2'd0};
    vecs[16] = '{2'd0, 5'd0, 5'd0,  1'b0, 1'b0, 1'b0, 5'd12, 5'd9,  0, 5'd0,  1'b0, 1'b0, 2'd0, 1'b0, 2'd0};
    vecs[17] = '{2'd0, 5'd0, 5'd0,  1'b0, 1'b0, 1'b0, 5'd12, 5'd9,  0, 5'd0,  1'b0, 1'b0, 2'd0, 1'b0, 2'd0};
    vecs[18] = '{2'd0, 5'd0, 5'd0,  1'b0, 1'b0, 1'b0, 5'd12, 5'd9,  1, 5'd0,  1'b0, 1'b0, 2'd0, 1'b0, 2'd0};

    // Reset asserted from time 0 with an active input; outputs must be zero without any edge.
    rst_n = 1'b0;
    drive(2'd3, 5'd0, 5'd8, 1'b1, 1'b0, 1'b0, 5'd8, 5'd8);
    #3;
    check_outs("reset t3", 1, 5'd0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0);
    #9;
    check_outs("reset t12", 1, 5'd0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0);
    #1 rst_n = 1'b1;

    for (int i = 0; i < 19; i++) begin
      drive(vecs[i].sel, vecs[i].rt, vecs[i].rd, vecs[i].v, vecs[i].st, vecs[i].fl,
            vecs[i].sa, vecs[i].sb);
      step();
      check_outs($sformatf("row%0d", i), vecs[i].ca, vecs[i].wa, vecs[i].we,
                 vecs[i].ha, vecs[i].da, vecs[i].hb, vecs[i].db);
    end

    // Stalled entry killed by a flush that coincides with stall; it must never write.
    drive(2'd3, 5'd0, 5'd20, 1'b1, 1'b0, 1'b0, 5'd20, 5'd20);
    step();
    check_outs("stall cap", 1, 5'd0, 1'b0, 1'b1, 2'd1, 1'b1, 2'd1);
    drive(2'd3, 5'd0, 5'd21, 1'b1, 1'b1, 1'b0, 5'd20, 5'd21);
    for (int c = 0; c < 2; c++) begin
      step();
      check_outs($sformatf("stall hold%0d", c), 1, 5'd0, 1'b0, 1'b1, 2'd1, 1'b0, 2'd0);
    end
    drive(2'd3, 5'd0, 5'd21, 1'b1, 1'b1, 1'b1, 5'd20, 5'd21);
    step();
    check_outs("stall flush", 0, 5'd0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0);
    drive(2'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd20, 5'd21);
    for (int c = 0; c < 3; c++) begin
      step();
      check_outs($sformatf("post flush%0d", c), 0, 5'd0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0);
    end

    // Two in-flight copies of r7: youngest wins; then an asynchronous reset pulse.
    drive(2'd0, 5'd7, 5'd0, 1'b1, 1'b0, 1'b0, 5'd7, 5'd3);
    step();
    drive(2'd0, 5'd3, 5'd0, 1'b0, 1'b0, 1'b0, 5'd7, 5'd3);
    step();
    drive(2'd0, 5'd7, 5'd0, 1'b1, 1'b0, 1'b0, 5'd7, 5'd3);
    step();
    check_outs("dup r7", 1, 5'd7, 1'b1, 1'b1, 2'd1, 1'b0, 2'd0);
    rst_n = 1'b0;
    #1;
    check_outs("async rst", 1, 5'd0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0);
    #2 rst_n = 1'b1;
    drive(2'd3, 5'd0, 5'd17, 1'b1, 1'b0, 1'b0, 5'd17, 5'd7);
    #1;
    check_outs("rst release", 1, 5'd0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0);
    step();
    check_outs("first cap", 1, 5'd0, 1'b0, 1'b1, 2'd1, 1'b0, 2'd0);
    drive(2'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd17, 5'd7);
    step();
    step();
    check_outs("first wb", 1, 5'd17, 1'b1, 1'b1, 2'd3, 1'b0, 2'd0);

    // Randomized traffic against the queue model.
    rst_n = 1'b0;
    #1 rst_n = 1'b1;
    m_reset();
    for (int n = 0; n < 3000; n++) begin
      sel = 2'($urandom_range(0, 3));
      rt = 5'($urandom); rd = 5'($urandom);
      in_valid = ($urandom_range(0, 3) != 0);
      stall = ($urandom_range(0, 3) == 0);
      flush = ($urandom_range(0, 9) == 0);
      pick = pipe[$urandom_range(0, D - 1)].a;
      src_a = ($urandom_range(0, 1) != 0) ? pick : 5'($urandom);
      pick = pipe[$urandom_range(0, D - 1)].a;
      src_b = ($urandom_range(0, 2) == 0) ? src_a : (($urandom_range(0, 1) != 0) ? pick
                                                                                  : 5'($urandom));
      m_edge();
      step();
      eda = m_dist(src_a);
      edb = m_dist(src_b);
      check_outs($sformatf("rnd%0d", n), pipe[D-1].k, pipe[D-1].a,
                 pipe[D-1].v && pipe[D-1].a != 5'd0, eda != 2'd0, eda, edb != 2'd0, edb);
      if ($urandom_range(0, 199) == 0) begin
        rst_n = 1'b0;
        #1;
        check_outs($sformatf("rnd%0d rst", n), 1, 5'd0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0);
        rst_n = 1'b1;
        m_reset();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_dest_pipeline.md
REG_DEST_PIPELINE -- requirements
Module: reg_dest_pipeline

Interface
REQ-001 Parameter: ADDR_W, default 5, width of a register address.
REQ-002 Parameter: DEPTH, default 3, number of pipeline stages the destination travels through (legal range 1..8).
REQ-003 Parameter: SP_IDX, default 29, fixed destination for sel=01.
REQ-004 Parameter: RA_IDX, default 31, fixed destination for sel=10.
REQ-005 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-006 Port: reset_n  input  1  reset, asynchronous, active-low.
REQ-007 Port: sel  input  2  destination select: 00 instr_rt, 01 SP_IDX, 10 RA_IDX, 11 instr_rd.
REQ-008 Port: instr_rt  input  ADDR_W  instruction bits [20:16].
REQ-009 Port: instr_rd  input  ADDR_W  instruction bits [15:11].
REQ-010 Port: in_valid  input  1  instruction at stage-0 input writes a register.
REQ-011 Port: stall  input  1  hold all stages.
REQ-012 Port: flush  input  1  kill all in-flight entries.
REQ-013 Port: src_a, src_b  input  ADDR_W each  source registers of the instruction being decoded.
REQ-014 Port: wb_addr  output  ADDR_W  destination leaving the last stage.
REQ-015 Port: wb_we  output  1  register-file write enable for wb_addr.
REQ-016 Port: hazard_a, hazard_b  output  1 each  src_a / src_b matches an in-flight destination.
REQ-017 Port: dist_a, dist_b  output  clog2(DEPTH+1)  stage distance (1..DEPTH) of youngest match; 0 when no match.

Function
REQ-018 Selected destination SHALL be computed combinationally from sel per REQ-007, truncated/zero-extended to ADDR_W for SP_IDX/RA_IDX.
REQ-019 Each stage k (0..DEPTH-1) SHALL hold {valid, addr}; stage 0 is youngest, stage DEPTH-1 drives wb_addr.
REQ-020 On a rising edge with stall=0, flush=0: stage 0 SHALL load {in_valid, selected addr}; stage k SHALL load stage k-1.
REQ-021 On a rising edge with stall=1, flush=0: all stages SHALL hold; inputs are ignored.
REQ-022 On a rising edge with flush=1: all valid bits SHALL clear regardless of stall and in_valid; addr contents are don't-care.
REQ-023 Latency: an entry captured at edge N SHALL appear at wb_addr after edge N+DEPTH-1 with no stalls; each stall cycle adds one.
REQ-024 wb_we SHALL equal valid of last stage AND wb_addr != 0; a destination of register 0 never writes.
REQ-025 wb_addr SHALL equal last-stage addr even when invalid.
REQ-026 hazard_a SHALL be 1 when any stage has valid=1, addr==src_a, addr!=0; hazard_b likewise for src_b; purely combinational from current state.
REQ-027 dist_a SHALL be k+1 of the lowest matching stage index k (youngest wins); dist_b likewise.
REQ-028 src_a==src_b SHALL yield identical hazard/dist outputs for both.
REQ-029 Hazard outputs SHALL not consider the entry currently at the stage-0 input (not yet captured).

Reset
REQ-030 reset_n=0 SHALL immediately clear all valid bits and all addr fields to 0, independent of clk.
REQ-031 During reset: wb_addr=0, wb_we=0, hazard_a=hazard_b=0, dist_a=dist_b=0.
REQ-032 Reset asserted mid-operation SHALL discard all in-flight entries; first capture occurs on the first rising edge after reset_n returns to 1.

Verification (DEPTH=3, ADDR_W=5)
REQ-033 sel=11, instr_rd=8, in_valid=1 one cycle, no stall -> wb_addr=8, wb_we=1 exactly after 3rd edge, for one cycle.
REQ-034 sel=01 then sel=10 back-to-back, valid -> wb_addr 29 then 31 on consecutive cycles, wb_we=1 both.
REQ-035 Entry rt=5 captured, src_a=5, src_b=5 -> hazard_a=hazard_b=1, dist=1, then 2, then 3, then 0 after it retires.
REQ-036 Entry dest=0 (sel=00, instr_rt=0) -> wb_we stays 0, hazard never asserts with src_a=0.
REQ-037 Entry captured, stall=1 for 2 cycles, then flush=1 with stall=1 -> entry never writes, all hazards 0 after flush edge.
REQ-038 Two entries both dest 7 in stages 0 and 2, src_a=7 -> dist_a=1; reset_n pulsed low between edges -> all outputs 0 immediately.
